// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state enum and sizing constants for the iterative multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int ITERS   = 8;
  localparam int DIGIT_W = 4;
  localparam int ACC_W   = 37;
  localparam int P_W     = 69;
  localparam int CNT_W   = $clog2(ITERS);

endpackage

// File: rtl/mult_pp_gen.sv
// rtl/mult_pp_gen.sv - radix-16 partial product: digit x multiplicand, 37-bit two's complement
module mult_pp_gen
  import mult_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic [31:0]        mcand,
  input  logic               sign_digit,
  input  logic               signed_mcand,
  output logic [ACC_W-1:0]   pp
);

  logic [ACC_W-1:0] dx;
  logic [ACC_W-1:0] mx;

  // Both operands extended to full width, so the low ACC_W bits of the
  // product are the correct signed/unsigned result.
  assign dx = {{(ACC_W-DIGIT_W){sign_digit & digit[DIGIT_W-1]}}, digit};
  assign mx = {{(ACC_W-32){signed_mcand & mcand[31]}}, mcand};
  assign pp = dx * mx;

endmodule

// File: rtl/mult_iter.sv
// rtl/mult_iter.sv - iterative 32x32 radix-16 multiplier, 8 compute cycles per product
// Optional MULT_UNSIGNED_EN adds the uns port (multu semantics when uns=1).
module mult_iter
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MULT_UNSIGNED_EN
  input  logic        uns,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t             state;
  logic [31:0]        mcand;
  logic [P_W-1:0]     p;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   pp;
  logic [P_W-DIGIT_W-1:0] sum;
  logic [P_W-1:0]     p_next;
  logic               last;
  logic               accept;
  logic               sign_digit;
  logic               signed_mcand;

  assign last   = (cnt == CNT_W'(ITERS-1));
  assign accept = start && (state != RUN);

`ifdef MULT_UNSIGNED_EN
  logic uns_q;
  assign signed_mcand = !uns_q;
  assign sign_digit   = last && !uns_q;
`else
  assign signed_mcand = 1'b1;
  assign sign_digit   = last;
`endif

  mult_pp_gen u_pp_gen (
    .digit        (p[DIGIT_W-1:0]),
    .mcand        (mcand),
    .sign_digit   (sign_digit),
    .signed_mcand (signed_mcand),
    .pp           (pp)
  );

  // The low digit is discarded by the shift and pp never reaches it,
  // so the add is done directly on the bits that survive.
  assign sum    = p[P_W-1:DIGIT_W] + {pp, {(32-DIGIT_W){1'b0}}};
  assign p_next = {{DIGIT_W{sum[P_W-DIGIT_W-1]}}, sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      p     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULT_UNSIGNED_EN
      uns_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand <= a;
        p     <= {{ACC_W{1'b0}}, b};
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
`ifdef MULT_UNSIGNED_EN
        uns_q <= uns;
`endif
      end else if (state == RUN) begin
        p   <= p_next;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          hi    <= p_next[63:32];
          lo    <= p_next[31:0];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mult_iter.sv
// tb/tb_mult_iter.sv - directed and random self-checking bench for mult_iter
module tb_mult_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        uns = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_res = '0;

  always #5 clk = ~clk;

  mult_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef MULT_UNSIGNED_EN
    .uns   (uns),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one multiply; optionally pokes a stray start mid-run.
  task automatic run_op(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                        input logic ui, input logic [63:0] exp, input bit poke);
    int n = 0;
    int nb = 0;
    bit both = 0;
    bit moved = 0;
    @(negedge clk);
    a = ai; b = bi; uns = ui; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 20) begin
      if (busy) nb++;
      if (busy && done) both = 1;
      if (done) break;
      if ({hi, lo} !== last_res) moved = 1;
      if (poke && n == 3) begin
        @(negedge clk);
        a = 32'd2; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd9);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd8);
    chk({tag, "_busy_done_excl"}, 64'(both), 64'd0);
    chk({tag, "_hold"}, 64'(moved), 64'd0);
    chk({tag, "_result"}, {hi, lo}, exp);
    last_res = exp;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        ru;
    longint      sa, sb;
    logic [63:0] rexp;
    int          nd;

    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("m3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 1'b0);
    @(negedge clk); @(negedge clk);
    run_op("mneg7x3", 32'hFFFF_FFF9, 32'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("mmin_sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b0);
    @(negedge clk);
    run_op("ignored_start", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 1'b1);
    run_op("b2b_2x9", 32'd2, 32'd9, 1'b0, 64'h0000_0000_0000_0012, 1'b0);

    // Reset during the fourth compute cycle aborts the operation.
    @(negedge clk);
    @(negedge clk);
    a = 32'd100; b = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    last_res = '0;
    run_op("m6x7", 32'd6, 32'd7, 1'b0, 64'h0000_0000_0000_002A, 1'b0);

`ifdef MULT_UNSIGNED_EN
    run_op("multu_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mult_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001, 1'b0);
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      ru = 1'b0;
`ifdef MULT_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`endif
      if (i % 7 == 0) ra = 32'h8000_0000;
      if (i % 11 == 0) rb = 32'hFFFF_FFFF;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      if (ru) rexp = {32'b0, ra} * {32'b0, rb};
      else    rexp = 64'(sa * sb);
      run_op("rand", ra, rb, ru, rexp, 1'b0);
      if (i % 3 == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
